hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Producer side of the EX-stage forwarding interface. Carries destination-register tags (rd, RegWrite, MemRead) for in-flight instructions through the ID/EX, EX/MEM and MEM/WB slots.
- Drives the EX_MEM/MEM_WB Rd and RegWrite signals that the forwarding logic compares against.
- Detects load-use hazards and requests a one-cycle stall with bubble insertion.
- Sits beside the ID stage and the pipeline registers in the 5-stage RISC-V CPU.

Parameters:
- REG_ADDR_W, 5, register address width (32 GPRs, x0 hardwired zero).
- CNT_W, 32, width of the optional stall-cycle counter.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-low reset.
- id_valid_i  input  1  a valid instruction is in ID.
- id_rs1_i  input  REG_ADDR_W  ID instruction rs1.
- id_rs2_i  input  REG_ADDR_W  ID instruction rs2.
- id_uses_rs2_i  input  1  ID instruction reads rs2 (R/S/B types).
- id_rd_i  input  REG_ADDR_W  ID instruction rd.
- id_regwrite_i  input  1  ID instruction writes rd.
- id_memread_i  input  1  ID instruction is a load.
- flush_i  input  1  kill the instruction in ID (branch taken).
- mem_busy_i  input  1  whole-pipeline freeze (multi-cycle memory).
- stall_o  output  1  hold PC and IF/ID; bubble into ID/EX.
- ex_rd_o  output  REG_ADDR_W  ID/EX slot rd.
- ex_regwrite_o  output  1  ID/EX slot RegWrite.
- ex_memread_o  output  1  ID/EX slot MemRead.
- ex_mem_rd_o  output  REG_ADDR_W  EX/MEM slot rd.
- ex_mem_regwrite_o  output  1  EX/MEM slot RegWrite.
- mem_wb_rd_o  output  REG_ADDR_W  MEM/WB slot rd.
- mem_wb_regwrite_o  output  1  MEM/WB slot RegWrite.
- pending_o  output  2**REG_ADDR_W  bitmap of registers with an in-flight write.
- stall_cnt_o  output  CNT_W  load-use stall cycle count.

Behaviour:
- Three slots, each holding {valid, rd, regwrite, memread}. A bubble is all zeros.
- Reset (rst_i=0 at a clk_i edge) clears all slots and stall_cnt_o. It overrides mem_busy_i and all other inputs. After reset, every output is 0.
- x0 normalisation on capture: if id_rd_i==0, regwrite and memread are stored as 0 and rd is stored as 0.
- hazard = id_valid_i & ex.valid & ex.memread & ex.rd!=0 & (ex.rd==id_rs1_i | (id_uses_rs2_i & ex.rd==id_rs2_i)).
- stall_o = hazard & ~flush_i. It is combinational from slot state and ID inputs. A flushed instruction is never stalled.
- Advance on each edge with mem_busy_i=0:
  - MEM/WB <= EX/MEM.
  - EX/MEM <= ID/EX.
  - ID/EX <= bubble if (stall_o | flush_i | ~id_valid_i); otherwise ID info.
- mem_busy_i=1: all slots hold. Outputs are frozen except stall_o, which still reflects hazard & ~flush_i.
- Latency: an instruction captured at edge n appears on ex_* after n, on ex_mem_* after n+1, and on mem_wb_* after n+2. Its tag drops out after n+3.
- Load-use costs exactly one stall cycle. After the bubble, the load sits in EX/MEM, hazard deasserts, and the consumer gets its value through the MEM/WB forward path.
- Non-load RAW dependencies never stall; they are covered by forwarding.
- pending_o[r]=1 iff some valid slot has regwrite=1 and rd==r. pending_o[0] is always 0. Combinational from slots.
- Each output *_rd_o / *_regwrite_o / ex_memread_o mirrors its slot directly (registered, no combinational path from inputs).

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- Defined: stall_cnt_o increments on each edge where stall_o=1 and mem_busy_i=0. It saturates at 2**CNT_W-1 and is cleared by reset.
- Undefined: stall_cnt_o is tied to 0 and no counter flops are built. All other behaviour is identical.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with id_valid_i=1, id_rd_i=7, id_regwrite_i=1 -> all outputs 0, pending_o=0. Release: ex_rd_o=7 one edge later.
- Load-use: lw x5 into ID, then add x6,x5,x1 -> stall_o=1 for exactly 1 cycle, then ex_rd_o=0/ex_regwrite_o=0 (bubble). The add enters ex_rd_o=6 one cycle later, mem_wb_rd_o=5 while the add is in EX, stall_cnt_o=1 (with macro).
- ALU RAW: add x5 then sub x7,x5,x2 -> stall_o stays 0; ex_mem_rd_o=5, ex_mem_regwrite_o=1 while sub is in EX; pending_o bits 5 and 7 set.
- x0 case: lw x0 then add x3,x0,x0 -> stall_o=0, ex_regwrite_o=0, pending_o=0 throughout.
- Freeze: mem_busy_i=1 for 3 cycles with lw x5 in EX and a dependent add in ID -> all slot outputs frozen, stall_o=1 but stall_cnt_o unchanged. After release: one counted stall, then normal flow.
- Flush vs hazard: lw x5 in EX, dependent instruction in ID, flush_i=1 -> stall_o=0, bubble enters ID/EX, stall_cnt_o unchanged.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - destination-tag scoreboard and load-use stall for the 5-stage pipeline
// Optional stall-cycle counter built only when HAZARD_STALL_CNT_EN is defined.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     id_valid_i,
  input  logic [REG_ADDR_W-1:0]    id_rs1_i,
  input  logic [REG_ADDR_W-1:0]    id_rs2_i,
  input  logic                     id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0]    id_rd_i,
  input  logic                     id_regwrite_i,
  input  logic                     id_memread_i,
  input  logic                     flush_i,
  input  logic                     mem_busy_i,
  output logic                     stall_o,
  output logic [REG_ADDR_W-1:0]    ex_rd_o,
  output logic                     ex_regwrite_o,
  output logic                     ex_memread_o,
  output logic [REG_ADDR_W-1:0]    ex_mem_rd_o,
  output logic                     ex_mem_regwrite_o,
  output logic [REG_ADDR_W-1:0]    mem_wb_rd_o,
  output logic                     mem_wb_regwrite_o,
  output logic [2**REG_ADDR_W-1:0] pending_o,
  output logic [CNT_W-1:0]         stall_cnt_o
);

  localparam int NREGS = 2**REG_ADDR_W;

  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_rw_q, ex_rw_d;
  logic                  ex_mr_q, ex_mr_d;
  logic                  exm_valid_q, exm_valid_d;
  logic [REG_ADDR_W-1:0] exm_rd_q, exm_rd_d;
  logic                  exm_rw_q, exm_rw_d;
  logic                  mwb_valid_q, mwb_valid_d;
  logic [REG_ADDR_W-1:0] mwb_rd_q, mwb_rd_d;
  logic                  mwb_rw_q, mwb_rw_d;

  logic hazard;
  logic id_rd_nz;

  assign id_rd_nz = (id_rd_i != '0);

  always_comb begin
    hazard = id_valid_i & ex_valid_q & ex_mr_q & (ex_rd_q != '0) &
             ((ex_rd_q == id_rs1_i) | (id_uses_rs2_i & (ex_rd_q == id_rs2_i)));
  end

  assign stall_o = hazard & ~flush_i;

  // MemRead only matters while the load sits in EX, so later slots drop it.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_rd_d     = ex_rd_q;
    ex_rw_d     = ex_rw_q;
    ex_mr_d     = ex_mr_q;
    exm_valid_d = exm_valid_q;
    exm_rd_d    = exm_rd_q;
    exm_rw_d    = exm_rw_q;
    mwb_valid_d = mwb_valid_q;
    mwb_rd_d    = mwb_rd_q;
    mwb_rw_d    = mwb_rw_q;
    if (!mem_busy_i) begin
      mwb_valid_d = exm_valid_q;
      mwb_rd_d    = exm_rd_q;
      mwb_rw_d    = exm_rw_q;
      exm_valid_d = ex_valid_q;
      exm_rd_d    = ex_rd_q;
      exm_rw_d    = ex_rw_q;
      if (stall_o | flush_i | ~id_valid_i) begin
        ex_valid_d = 1'b0;
        ex_rd_d    = '0;
        ex_rw_d    = 1'b0;
        ex_mr_d    = 1'b0;
      end else begin
        ex_valid_d = 1'b1;
        ex_rd_d    = id_rd_i;
        ex_rw_d    = id_regwrite_i & id_rd_nz;
        ex_mr_d    = id_memread_i & id_rd_nz;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      exm_valid_q <= 1'b0;
      exm_rd_q    <= '0;
      exm_rw_q    <= 1'b0;
      mwb_valid_q <= 1'b0;
      mwb_rd_q    <= '0;
      mwb_rw_q    <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_mr_q     <= ex_mr_d;
      exm_valid_q <= exm_valid_d;
      exm_rd_q    <= exm_rd_d;
      exm_rw_q    <= exm_rw_d;
      mwb_valid_q <= mwb_valid_d;
      mwb_rd_q    <= mwb_rd_d;
      mwb_rw_q    <= mwb_rw_d;
    end
  end

  assign ex_rd_o           = ex_rd_q;
  assign ex_regwrite_o     = ex_rw_q;
  assign ex_memread_o      = ex_mr_q;
  assign ex_mem_rd_o       = exm_rd_q;
  assign ex_mem_regwrite_o = exm_rw_q;
  assign mem_wb_rd_o       = mwb_rd_q;
  assign mem_wb_regwrite_o = mwb_rw_q;

  always_comb begin
    pending_o = '0;
    for (int r = 1; r < NREGS; r++) begin
      pending_o[r] = (ex_valid_q  & ex_rw_q  & (ex_rd_q  == REG_ADDR_W'(r))) |
                     (exm_valid_q & exm_rw_q & (exm_rd_q == REG_ADDR_W'(r))) |
                     (mwb_valid_q & mwb_rw_q & (mwb_rd_q == REG_ADDR_W'(r)));
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && !mem_busy_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

`ifdef HAZARD_STALL_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_uses_rs2_i;
  logic [4:0]  id_rd_i;
  logic        id_regwrite_i;
  logic        id_memread_i;
  logic        flush_i;
  logic        mem_busy_i;
  logic        stall_o;
  logic [4:0]  ex_rd_o;
  logic        ex_regwrite_o;
  logic        ex_memread_o;
  logic [4:0]  ex_mem_rd_o;
  logic        ex_mem_regwrite_o;
  logic [4:0]  mem_wb_rd_o;
  logic        mem_wb_regwrite_o;
  logic [31:0] pending_o;
  logic [31:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  hazard_scoreboard dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .id_valid_i       (id_valid_i),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .id_uses_rs2_i    (id_uses_rs2_i),
    .id_rd_i          (id_rd_i),
    .id_regwrite_i    (id_regwrite_i),
    .id_memread_i     (id_memread_i),
    .flush_i          (flush_i),
    .mem_busy_i       (mem_busy_i),
    .stall_o          (stall_o),
    .ex_rd_o          (ex_rd_o),
    .ex_regwrite_o    (ex_regwrite_o),
    .ex_memread_o     (ex_memread_o),
    .ex_mem_rd_o      (ex_mem_rd_o),
    .ex_mem_regwrite_o(ex_mem_regwrite_o),
    .mem_wb_rd_o      (mem_wb_rd_o),
    .mem_wb_regwrite_o(mem_wb_regwrite_o),
    .pending_o        (pending_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic rw, input logic mr);
    id_valid_i    = v;
    id_rs1_i      = rs1;
    id_rs2_i      = rs2;
    id_uses_rs2_i = u2;
    id_rd_i       = rd;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    #1;
  endtask

  task automatic nop_drain();
    set_id(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    step();
  endtask

  initial begin
    rst_i      = 1'b0;
    flush_i    = 1'b0;
    mem_busy_i = 1'b0;
    set_id(1, 0, 0, 0, 7, 1, 0);

    // Reset held two edges with a live instruction in ID
    step();
    step();
    chk("rst_ex_rd", ex_rd_o, 0);
    chk("rst_ex_rw", ex_regwrite_o, 0);
    chk("rst_ex_mr", ex_memread_o, 0);
    chk("rst_exm_rd", ex_mem_rd_o, 0);
    chk("rst_exm_rw", ex_mem_regwrite_o, 0);
    chk("rst_mwb_rd", mem_wb_rd_o, 0);
    chk("rst_mwb_rw", mem_wb_regwrite_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_cnt", stall_cnt_o, 0);
    rst_i = 1'b1;
    step();
    chk("rel_ex_rd", ex_rd_o, 7);
    chk("rel_ex_rw", ex_regwrite_o, 1);
    chk("rel_pending", pending_o, 32'h80);
    nop_drain();
    chk("drain_pending", pending_o, 0);
    chk("drain_mwb_rw", mem_wb_regwrite_o, 0);

    // Load-use: lw x5 ; add x6,x5,x1
    set_id(1, 2, 0, 0, 5, 1, 1);
    step();
    chk("lu_ex_mr", ex_memread_o, 1);
    set_id(1, 5, 1, 1, 6, 1, 0);
    chk("lu_stall_on", stall_o, 1);
    step();
    exp_cnt += CNT_EN;
    chk("lu_bubble_rd", ex_rd_o, 0);
    chk("lu_bubble_rw", ex_regwrite_o, 0);
    chk("lu_exm_rd", ex_mem_rd_o, 5);
    chk("lu_stall_off", stall_o, 0);
    chk("lu_cnt", stall_cnt_o, exp_cnt);
    step();
    chk("lu_add_ex_rd", ex_rd_o, 6);
    chk("lu_mwb_rd", mem_wb_rd_o, 5);
    chk("lu_mwb_rw", mem_wb_regwrite_o, 1);
    chk("lu_pending", pending_o, 32'h60);
    nop_drain();

    // ALU RAW: add x5 ; sub x7,x5,x2
    set_id(1, 1, 2, 1, 5, 1, 0);
    step();
    set_id(1, 5, 2, 1, 7, 1, 0);
    chk("raw_stall", stall_o, 0);
    step();
    chk("raw_ex_rd", ex_rd_o, 7);
    chk("raw_exm_rd", ex_mem_rd_o, 5);
    chk("raw_exm_rw", ex_mem_regwrite_o, 1);
    chk("raw_pending", pending_o, 32'hA0);
    chk("raw_stall2", stall_o, 0);
    nop_drain();

    // x0 destination: lw x0 ; add x3,x0,x0
    set_id(1, 1, 0, 0, 0, 1, 1);
    step();
    chk("x0_ex_rw", ex_regwrite_o, 0);
    chk("x0_ex_mr", ex_memread_o, 0);
    chk("x0_pending", pending_o, 0);
    set_id(1, 0, 0, 1, 3, 1, 0);
    chk("x0_stall", stall_o, 0);
    step();
    chk("x0_exm_rw", ex_mem_regwrite_o, 0);
    chk("x0_pending_add", pending_o, 32'h8);
    nop_drain();

    // Freeze with load in EX and dependent add in ID
    set_id(1, 2, 0, 0, 5, 1, 1);
    step();
    set_id(1, 5, 1, 1, 6, 1, 0);
    mem_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("frz_ex_rd", ex_rd_o, 5);
      chk("frz_ex_mr", ex_memread_o, 1);
      chk("frz_exm_rd", ex_mem_rd_o, 0);
      chk("frz_stall", stall_o, 1);
      chk("frz_cnt", stall_cnt_o, exp_cnt);
    end
    mem_busy_i = 1'b0;
    #1;
    chk("frz_rel_stall", stall_o, 1);
    step();
    exp_cnt += CNT_EN;
    chk("frz_bubble_rd", ex_rd_o, 0);
    chk("frz_exm_rd2", ex_mem_rd_o, 5);
    chk("frz_stall_off", stall_o, 0);
    chk("frz_cnt2", stall_cnt_o, exp_cnt);
    step();
    chk("frz_add_ex_rd", ex_rd_o, 6);
    chk("frz_mwb_rd", mem_wb_rd_o, 5);
    nop_drain();

    // Flush beats hazard; rs2 only matters when used
    set_id(1, 2, 0, 0, 5, 1, 1);
    step();
    set_id(1, 1, 5, 0, 6, 1, 0);
    chk("rs2_unused_stall", stall_o, 0);
    set_id(1, 1, 5, 1, 6, 1, 0);
    chk("rs2_used_stall", stall_o, 1);
    flush_i = 1'b1;
    #1;
    chk("fl_stall", stall_o, 0);
    step();
    chk("fl_ex_rd", ex_rd_o, 0);
    chk("fl_ex_rw", ex_regwrite_o, 0);
    chk("fl_exm_rd", ex_mem_rd_o, 5);
    chk("fl_cnt", stall_cnt_o, exp_cnt);
    flush_i = 1'b0;

    // Reset overrides freeze
    set_id(1, 2, 0, 0, 9, 1, 1);
    step();
    set_id(0, 0, 0, 0, 0, 0, 0);
    mem_busy_i = 1'b1;
    rst_i = 1'b0;
    step();
    chk("rstbusy_ex_rd", ex_rd_o, 0);
    chk("rstbusy_exm_rd", ex_mem_rd_o, 0);
    chk("rstbusy_pending", pending_o, 0);
    chk("rstbusy_cnt", stall_cnt_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
